instr_issuer: RTL
=================

Name: instr_issuer

Overview:
- Instruction-supply side of the simple_cpu instruction port.
- Holds a small writable program store and issues one INSTR_WIDTH-bit instruction at a time to the CPU.
- Holds each instruction stable until the CPU acknowledges completion, then advances the program counter.
- Replaces bench-driven instruction sequencing with a self-contained sequencer for directed and self-running CPU runs.

Parameters:
- INSTR_WIDTH, 20: instruction width; matches simple_cpu.
- PROG_ADDR_BITS, 4: program store depth is 2^PROG_ADDR_BITS (16) entries.
- TIMEOUT_CYCLES, 16: ISSUE-state watchdog limit; used only with ISSUE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- prog_we  input  1  program store write enable; honoured in IDLE only.
- prog_addr  input  PROG_ADDR_BITS  program store write address.
- prog_data  input  INSTR_WIDTH  program store write data.
- prog_len  input  PROG_ADDR_BITS+1  number of instructions to run; sampled on start.
- start  input  1  one-cycle run request; honoured in IDLE only.
- abort  input  1  synchronous run cancel.
- instr_done  input  1  CPU completion pulse for the currently issued instruction.
- instruction  output  INSTR_WIDTH  instruction to the CPU; registered.
- instr_valid  output  1  instruction is valid and held.
- pc  output  PROG_ADDR_BITS  index of the current instruction.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- err  output  1  timeout flag; sticky.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - instruction=0, instr_valid=0, pc=0, busy=0, done=0, err=0.
  - Latched length = 0.
  - Program store contents are not reset.
- IDLE:
  - prog_we=1 writes mem[prog_addr]=prog_data at the clock edge.
  - start=1 with prog_len!=0: latch len=prog_len, pc=0, busy=1, go to FETCH.
  - start=1 with prog_len==0: go to DONE, no instruction issued.
  - start and prog_we in the same cycle: the write completes and the run starts. The written word is visible to the FETCH that follows.
- FETCH, 1 cycle:
  - Synchronous read of mem[pc] into the instruction register.
  - Go to ISSUE. instruction and instr_valid=1 are visible from the first ISSUE cycle.
- ISSUE:
  - instr_valid=1; instruction held stable.
  - On instr_done=1: instr_valid=0 on the next cycle. instruction keeps its last value.
  - Then, if pc==len-1, go to DONE; otherwise pc<=pc+1 and go to FETCH.
  - Minimum cost per instruction is 2 cycles (FETCH + 1 ISSUE cycle).
- DONE, 1 cycle:
  - done=1, busy=0, then return to IDLE.
  - pc keeps the index of the last instruction.
- instr_done outside ISSUE is ignored.
- start, prog_we and instr_done are all ignored while busy (FETCH, ISSUE, DONE).
- abort=1 in FETCH or ISSUE:
  - Next cycle: IDLE, instr_valid=0, busy=0, no done pulse, pc unchanged.
  - abort has priority over instr_done in the same cycle.
  - abort in IDLE or DONE has no effect.
- Width rules:
  - prog_len up to 2^PROG_ADDR_BITS is legal; pc never exceeds len-1, so pc does not wrap.
  - prog_len > 2^PROG_ADDR_BITS is clamped to 2^PROG_ADDR_BITS.
- err clears on an accepted start.
- Reset mid-run returns immediately to the reset values above. Program contents survive.

Optional Feature:
- Macro: ISSUE_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ISSUE and counts each ISSUE cycle without instr_done.
  - When TIMEOUT_CYCLES consecutive ISSUE cycles pass without instr_done: err<=1, instr_valid<=0, go to DONE. done still pulses.
- Undefined:
  - No counter; ISSUE waits indefinitely.
  - err is tied to 0.

Test Plan:
- Reset check: assert rst=0 mid-operation -> all outputs return to 0 asynchronously, before the next clk edge.
- Three-instruction run:
  - Stimulus: load mem[0..2] = 20'h47000, 20'h53000, 20'h72001; prog_len=3; pulse start; CPU model returns instr_done 3 cycles after each instr_valid rises.
  - Required: the three words are issued in order with pc=0,1,2; instr_valid drops 1 cycle after each instr_done; done pulses once; busy=0 afterwards.
- Zero-length run: prog_len=0, pulse start -> done pulses on the next cycle; instr_valid never asserts.
- Ignored inputs while busy: during ISSUE, drive prog_we to mem[1]=20'hFFFFF and pulse start -> neither has any effect; mem[1] is still issued with its original contents.
- Abort priority: abort=1 together with instr_done in ISSUE at pc=1 -> IDLE next cycle, no done pulse, pc=1.
- Timeout (ISSUE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): never return instr_done -> after 16 ISSUE cycles err=1 and done pulses; the next start clears err.

Source files
------------

// File: rtl/instr_issuer.sv
// Instruction issuer: writable program store that feeds simple_cpu one held instruction at a time.
// Optional ISSUE-state watchdog enabled by defining ISSUE_TIMEOUT_EN.
module instr_issuer #(
  parameter int unsigned INSTR_WIDTH    = 20,
  parameter int unsigned PROG_ADDR_BITS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      instr_done,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int unsigned LenW  = PROG_ADDR_BITS + 1;
  localparam int unsigned Depth = 1 << PROG_ADDR_BITS;
  localparam logic [LenW-1:0] MaxLen = LenW'(Depth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [LenW-1:0]           len_q, len_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      mem_we_c;
  logic [LenW-1:0]           len_clamp_c;
  logic                      last_c;

  logic [INSTR_WIDTH-1:0] mem [Depth];

`ifdef ISSUE_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  logic             err_q, err_d;
  logic [WaitW-1:0] wait_q, wait_d;
`endif

  // Lengths beyond the store depth run the whole store once.
  assign len_clamp_c = (prog_len > MaxLen) ? MaxLen : prog_len;
  assign last_c      = ({1'b0, pc_q} == (len_q - LenW'(1)));

  // Program store: no reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
      err_q   <= 1'b0;
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ISSUE_TIMEOUT_EN
      err_q   <= err_d;
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mem_we_c = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
    err_d    = err_q;
    wait_d   = wait_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        mem_we_c = prog_we;
        if (start) begin
          len_d = len_clamp_c;
`ifdef ISSUE_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (len_clamp_c != '0) begin
            pc_d    = '0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          instr_d = mem[pc_q];
          valid_d = 1'b1;
          state_d = S_ISSUE;
`ifdef ISSUE_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (instr_done) begin
          valid_d = 1'b0;
          if (last_c) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PROG_ADDR_BITS'(1);
            state_d = S_FETCH;
          end
        end
`ifdef ISSUE_TIMEOUT_EN
        else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef ISSUE_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule
